// File: rtl/imm_encoder.sv
// Instruction immediate packer: writes a signed immediate into the I/S/B/J bit
// positions of a base instruction word. It uses a two-stage valid/ready pipeline
// with saturating handoff counters.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       imm_sel,
   input  logic [31:0]      imm_in,
   input  logic [31:0]      base_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {SEL_I = 2'b00, SEL_S = 2'b01, SEL_B = 2'b10, SEL_J = 2'b11} sel_t;

   logic        s1_valid;
   logic [31:0] s1_inst;
   sel_t        s1_sel;
   logic [19:0] s1_imm;
   logic        s1_err;

   logic        s2_adv, s1_adv, accept, handoff;
   logic        fit12, fit20, in_err;
   logic [31:0] packed_inst;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready;

   // The upper immediate bits must all equal the sign bit of the field.
   assign fit12  = (&imm_in[31:11]) || !(|imm_in[31:11]);
   assign fit20  = (&imm_in[31:19]) || !(|imm_in[31:19]);
   assign in_err = (sel_t'(imm_sel) == SEL_J) ? !fit20 : !fit12;

   always_comb begin
      // NOTE: default first so every path assigns packed_inst; no latch is inferred.
      packed_inst = s1_inst;
      unique case (s1_sel)
         SEL_I: packed_inst[31:20] = s1_imm[11:0];
         SEL_S: begin
            packed_inst[31:25] = s1_imm[11:5];
            packed_inst[11:7]  = s1_imm[4:0];
         end
         SEL_B: begin
            packed_inst[31]    = s1_imm[11];
            packed_inst[7]     = s1_imm[10];
            packed_inst[30:25] = s1_imm[9:4];
            packed_inst[11:8]  = s1_imm[3:0];
         end
         SEL_J: begin
            packed_inst[31]    = s1_imm[19];
            packed_inst[19:12] = s1_imm[18:11];
            packed_inst[20]    = s1_imm[10];
            packed_inst[30:21] = s1_imm[9:0];
         end
      endcase
   end

   // NOTE: stage-1 payload needs no reset; s1_valid qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_inst <= base_inst;
         s1_sel  <= sel_t'(imm_sel);
         s1_imm  <= imm_in[19:0];
         s1_err  <= in_err;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_err   <= 1'b0;
         enc_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            if (s1_adv) s1_valid <= accept;
            if (s2_adv) out_valid <= s1_valid;
         end
         if (s2_adv && s1_valid && !flush) begin
            out_inst <= packed_inst;
            out_err  <= s1_err;
         end
         // A handoff in a flush cycle still counts.
         if (handoff && !(&enc_cnt)) enc_cnt <= enc_cnt + CNT_W'(1);
         if (handoff && out_err && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule
